// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider answering the EX-stage
// divide handshake. Returns {remainder, quotient} after 33 clocks.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor seen in IDLE completes on
// the next edge with {operand1, all-ones} instead of iterating.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               flag_unsigned,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  output logic [2*WIDTH-1:0] result,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;
  logic [WIDTH-1:0]   quo_q,    quo_d;
  logic [WIDTH-1:0]   div_q,    div_d;
  logic [WIDTH-1:0]   op1_q,    op1_d;
  logic [WIDTH-1:0]   op2_q,    op2_d;
  logic               uns_q,    uns_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q,   done_d;

  logic               fast_zero;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               borrow;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic               same_request;

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (operand2 == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // Datapath: operand magnitudes, one restoring step, and the final sign fix
  always_comb begin
    op1_abs   = (!flag_unsigned && operand1[WIDTH-1]) ? (~operand1 + 1'b1) : operand1;
    op2_abs   = (!flag_unsigned && operand2[WIDTH-1]) ? (~operand2 + 1'b1) : operand2;
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = {1'b0, shifted} - {2'b00, div_q};
    borrow    = trial[WIDTH+1];
    q_neg     = !uns_q && (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
    r_neg     = !uns_q && op1_q[WIDTH-1];
    quo_fixed = q_neg ? (~quo_q + 1'b1) : quo_q;
    rem_fixed = r_neg ? (~rem_q + 1'b1) : rem_q;
    same_request = start && (operand1 == op1_q) && (operand2 == op2_q) &&
                   (flag_unsigned == uns_q);
  end

  // Next-state logic for the IDLE/BUSY/DONE handshake and the iteration registers
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    uns_d    = uns_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op1_d = operand1;
          op2_d = operand2;
          uns_d = flag_unsigned;
          if (fast_zero) begin
            result_d = {operand1, {WIDTH{1'b1}}};
            state_d  = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = op1_abs;
            div_d   = op2_abs;
            count_d = CW'(WIDTH);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!start) begin
          state_d = IDLE;
        end else if (count_q != '0) begin
          rem_d   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_d   = {quo_q[WIDTH-2:0], ~borrow};
          count_d = count_q - CW'(1);
        end else begin
          result_d = {rem_fixed, quo_fixed};
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!same_request) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      uns_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      uns_q    <= uns_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: table-driven and scoreboarded bench for iter_divider.
module tb_iter_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic        flag_unsigned;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [63:0] result;
  logic        done;

  int passed_count = 0;
  int total_count  = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        uns;
    logic [63:0] res;
  } vec_t;

  exp_t        sb_q[$];
  logic [63:0] last_result;
  vec_t        vecs[8];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 33;
`endif

  iter_divider #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .flag_unsigned (flag_unsigned),
    .operand1      (operand1),
    .operand2      (operand2),
    .result        (result),
    .done          (done)
  );

  // Free-running core clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something never terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_count++;
    if (act === exp) passed_count++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic u);
    operand1      = a;
    operand2      = b;
    flag_unsigned = u;
    start         = 1'b1;
  endtask

  task automatic push_expect(input logic [63:0] r, input int lat);
    exp_t e;
    e.res = r;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for done, then pop the oldest expectation and compare it
  task automatic collect(input string name);
    exp_t e;
    int   edges;
    bit   seen;
    edges = 0;
    seen  = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      edges++;
      if (done === 1'b1) seen = 1;
    end
    e = sb_q.pop_front();
    if (!seen) check_output({name, "_timeout"}, 64'(done), 64'd1);
    check_output({name, "_result"}, result, e.res);
    check_output({name, "_latency"}, 64'(edges - 1), 64'(e.lat));
    last_result = e.res;
  endtask

  initial begin
    vecs[0] = '{32'd100,        32'd7,          1'b1, 64'h00000002_0000000E};
    vecs[1] = '{32'hFFFFFFFF,   32'd1,          1'b1, 64'h00000000_FFFFFFFF};
    vecs[2] = '{32'hFFFFFFF9,   32'd2,          1'b0, 64'hFFFFFFFF_FFFFFFFD};
    vecs[3] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 64'h00000000_80000000};
    vecs[4] = '{32'd7,          32'hFFFFFFFE,   1'b0, 64'h00000001_FFFFFFFD};
    vecs[5] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b0, 64'hFFFFFFFE_0000000E};
    vecs[6] = '{32'hFFFFFFFF,   32'h00000010,   1'b1, 64'h0000000F_0FFFFFFF};
    vecs[7] = '{32'd3,          32'd5,          1'b1, 64'h00000003_00000000};

    reset         = 1'b1;
    start         = 1'b0;
    flag_unsigned = 1'b1;
    operand1      = '0;
    operand2      = '0;
    last_result   = '0;

    // Reset held two cycles with a request already pending
    apply_stimulus(32'd100, 32'd7, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output("reset_done", 64'(done), 64'd0);
      check_output("reset_result", result, 64'd0);
    end
    reset = 1'b0;
    push_expect(64'h00000002_0000000E, 33);
    collect("after_reset");

    // Hold start with unchanged operands: done and result must stay put
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("hold_done", 64'(done), 64'd1);
      check_output("hold_result", result, 64'h00000002_0000000E);
    end

    // New operands while in DONE: drop next cycle, then restart (34 total)
    apply_stimulus(32'd9, 32'd4, 1'b1);
    tick();
    check_output("b2b_drop_done", 64'(done), 64'd0);
    check_output("b2b_drop_result", result, 64'h00000002_0000000E);
    push_expect(64'h00000001_00000002, 33);
    collect("b2b");

    // Table of independent divides
    for (int v = 0; v < 8; v++) begin
      start = 1'b0;
      tick();
      check_output($sformatf("idle_done_%0d", v), 64'(done), 64'd0);
      apply_stimulus(vecs[v].op1, vecs[v].op2, vecs[v].uns);
      push_expect(vecs[v].res, 33);
      collect($sformatf("vec%0d", v));
    end

    // Abort at iteration 10, result must keep its previous value
    start = 1'b0;
    tick();
    apply_stimulus(32'd100, 32'd7, 1'b1);
    for (int i = 0; i < 11; i++) tick();
    check_output("abort_busy_done", 64'(done), 64'd0);
    start = 1'b0;
    tick();
    check_output("abort_done", 64'(done), 64'd0);
    check_output("abort_result", result, last_result);
    tick();
    check_output("abort_idle_done", 64'(done), 64'd0);

    // Re-assert: full latency; operands changed after acceptance are ignored
    apply_stimulus(32'd1000, 32'd10, 1'b1);
    tick();
    operand1 = 32'd7;
    operand2 = 32'd3;
    push_expect(64'h00000000_00000064, 32);
    collect("restart_ignore_ops");

    // Zero divisor, unsigned and signed
    start = 1'b0;
    tick();
    apply_stimulus(32'd5, 32'd0, 1'b1);
    push_expect(64'h00000005_FFFFFFFF, ZERO_LAT);
    collect("zero_unsigned");

    start = 1'b0;
    tick();
    apply_stimulus(32'hFFFFFFFB, 32'd0, 1'b0);
`ifdef DIV_ZERO_FAST_EN
    push_expect(64'hFFFFFFFB_FFFFFFFF, ZERO_LAT);
`else
    push_expect(64'hFFFFFFFB_00000001, ZERO_LAT);
`endif
    collect("zero_signed");

    start = 1'b0;
    tick();
    check_output("final_idle_done", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", passed_count, total_count);
    $finish;
  end

endmodule
